// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle MIPS main control unit and the datapath.
//
// Handshake: mem_ready is a single-cycle completion indication. A memory
// access (fetch in FETCH, load in MEMRD, store in MEMWR) is presented by the
// controller and held steady; the access completes in the cycle where
// mem_ready=1 is sampled, and the controller advances on that edge.
//
// Signals:
//   opcode     datapath -> ctrl  IR[31:26], meaningful from DECODE onward
//   mem_ready  datapath -> ctrl  memory completes the current access
//   iord, memwrite, irwrite, pcwrite, branch, regwrite, regdst, memtoreg,
//   alusrca, alusrcb[1:0], aluop[1:0], pcsrc[1:0]   ctrl -> datapath
//   illegal_op ctrl -> datapath  one-cycle pulse on an unknown opcode
//   state[3:0] ctrl -> observer  current state encoding (debug)
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       illegal_op;
  logic [3:0] state;

  // Controller side
  modport master (
    input  opcode, mem_ready,
    output iord, memwrite, irwrite, pcwrite, branch, regwrite, regdst,
           memtoreg, alusrca, alusrcb, aluop, pcsrc, illegal_op, state
  );

  // Datapath side
  modport slave (
    output opcode, mem_ready,
    input  iord, memwrite, irwrite, pcwrite, branch, regwrite, regdst,
           memtoreg, alusrca, alusrcb, aluop, pcsrc, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control unit. Moore-style FSM that decodes the opcode
// and sequences PC, memory, IR, register file and ALU source muxes.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; also forces all outputs to 0
//   bus    control bus (master modport): opcode/mem_ready in, strobes out
module mips_multicycle_control (
  input  logic                         clk,
  input  logic                         rst_n,
  mips_multicycle_control_if.master    bus
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t state_q, state_d;
  // The opcode is only trusted during DECODE, so the lw/sw choice made
  // there is remembered for MEMADR.
  logic   is_sw_q, is_sw_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    is_sw_d        = is_sw_q;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.branch     = 1'b0;
    bus.regwrite   = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.aluop      = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.illegal_op = 1'b0;
    bus.state      = state_q;

    case (state_q)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        is_sw_d     = (bus.opcode == OP_SW);
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d        = S_FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        bus.branch  = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        bus.pcsrc   = 2'b10;
        bus.pcwrite = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences the datapath immediately, even before the edge.
    if (!rst_n) begin
      bus.iord       = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.pcwrite    = 1'b0;
      bus.branch     = 1'b0;
      bus.regwrite   = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.aluop      = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.illegal_op = 1'b0;
      bus.state      = 4'd0;
    end
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle MIPS main control unit. A Moore-style state machine decodes the 6-bit opcode and sequences the shared datapath: PC, memory, IR, register file, ALU source muxes and the shift-left-2 branch/jump target paths. Instruction and data memory accesses stall on a `mem_ready` handshake. Sits beside the ALU decoder in the processor top level and drives every datapath enable and mux select.

## Interface
Parameters:
- none (opcode encodings fixed: lw 6'b100011, sw 6'b101011, R-type 6'b000000, beq 6'b000100, addi 6'b001000, j 6'b000010)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  memory address select (0 = PC, 1 = ALUOut)
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- pcwrite  out  1  unconditional PC load
- branch  out  1  conditional PC load (datapath ANDs with zero)
- regwrite  out  1  register file write enable
- regdst  out  1  write register select (0 = rt, 1 = rd)
- memtoreg  out  1  write-back data select (0 = ALUOut, 1 = MDR)
- alusrca  out  1  ALU A select (0 = PC, 1 = A reg)
- alusrcb  out  2  ALU B select (00 = B reg, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2)
- aluop  out  2  to ALU decoder (00 add, 01 sub, 10 funct)
- pcsrc  out  2  PC source (00 = ALU result, 01 = ALUOut, 10 = jump target)
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- state  out  4  current state encoding, for debug

## Operation
- States and encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Encodings 12-15 are unreachable and go to FETCH.
- Every output is 0 unless listed for the current state.
- FETCH: alusrcb=01; irwrite=pcwrite=mem_ready. Stays in FETCH while mem_ready=0, else goes to DECODE.
- DECODE: alusrcb=11, which precomputes the branch target into ALUOut. Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXECUTE
  - beq -> BRANCH
  - addi -> ADDIEXEC
  - j -> JUMP
  - other -> FETCH, with illegal_op=1 in this DECODE cycle
- MEMADR: alusrca=1, alusrcb=10. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR: iord=1, memwrite=1. memwrite stays held until the cycle mem_ready=1 is seen, then goes to FETCH.
- EXECUTE: alusrca=1, aluop=10. Goes to ALUWB.
- ALUWB: regdst=1, regwrite=1. Goes to FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1. Goes to FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10. Goes to ADDIWB.
- ADDIWB: regwrite=1. Goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1. Goes to FETCH.

## Timing
- Reset:
  - rst_n sampled low at an edge -> state=FETCH.
  - While rst_n=0, all outputs are forced to 0 combinationally, including irwrite/pcwrite and state=0.
  - Reset mid-instruction abandons it with no further writes.
- Latency with mem_ready held at 1, counted in cycles including FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes hold steady during a stall, except irwrite/pcwrite, which track mem_ready.
- opcode changes outside DECODE are ignored.
- illegal_op is exactly one cycle wide. The next FETCH follows immediately.
- No output is registered: each output is a function of state (and mem_ready / opcode where stated) within the same cycle.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1 -> all outputs 0 during reset; state=0 and FETCH strobes appear on the first cycle after release.
- lw, mem_ready=1 -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in cycle 5; irwrite only in cycle 1.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state=0. regwrite is never asserted.
- R, beq, addi, j back-to-back, mem_ready=1 -> state sequences 0,1,6,7 / 0,1,8 / 0,1,9,10 / 0,1,11.
  - beq: branch=1, pcsrc=01, aluop=01 in state 8.
  - j: pcwrite=1, pcsrc=10 in state 11.
- Illegal opcode 6'b111111 -> illegal_op=1 for one cycle in DECODE, then FETCH. No write strobe asserted.
- Fetch stall plus reset: mem_ready=0 for 5 cycles in FETCH -> irwrite=pcwrite=0 and state held at 0. Separately, rst_n=0 during MEMRD -> state=0 on the next edge and no regwrite.
